// File: rtl/sd_pkg.sv
// Shared definitions for the SD card command sequencer.
//  - SD command index constants used during bring-up and block transfers
//  - fixed command arguments (CMD8 check pattern, ACMD41 OCR request, ACMD6 bus width)
//  - state encoding of the sequencer FSM
package sd_pkg;

  localparam logic [5:0] CMD2  = 6'd2;
  localparam logic [5:0] CMD3  = 6'd3;
  localparam logic [5:0] CMD7  = 6'd7;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD24 = 6'd24;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] ACMD6 = 6'd6;

  // CMD8: VHS = 2.7-3.6 V, check pattern 0xAA; the card echoes the low 12 bits
  localparam logic [31:0] CMD8_ARG   = 32'h0000_01AA;
  localparam logic [11:0] CMD8_ECHO  = 12'h1AA;
  // ACMD41: HCS=1, voltage window 2.7-3.6 V
  localparam logic [31:0] ACMD41_ARG = 32'h40FF_8000;
  // ACMD6: 4-bit bus
  localparam logic [31:0] ACMD6_ARG  = 32'h0000_0002;

  // Every command owns an ISSUE state (ostart pulse) and a WAIT state (hold until idone)
  typedef enum logic [4:0] {
    ST_PWR_WAIT,
    ST_CMD8_ISSUE,   ST_CMD8_WAIT,
    ST_APP41_ISSUE,  ST_APP41_WAIT,
    ST_ACMD41_ISSUE, ST_ACMD41_WAIT,
    ST_CMD2_ISSUE,   ST_CMD2_WAIT,
    ST_CMD3_ISSUE,   ST_CMD3_WAIT,
    ST_CMD7_ISSUE,   ST_CMD7_WAIT,
    ST_APP6_ISSUE,   ST_APP6_WAIT,
    ST_ACMD6_ISSUE,  ST_ACMD6_WAIT,
    ST_READY,
    ST_XFER_ISSUE,   ST_XFER_WAIT,
    ST_ERROR
  } sd_state_e;

endpackage

// File: rtl/sd_cmd_sequencer.sv
// SD card command sequencer.
// Walks the card through bring-up (CMD8, CMD55/ACMD41 loop, CMD2, CMD3, CMD7,
// CMD55/ACMD6), then serves single-block CMD17/CMD24 requests from the data path.
// Sole master of the CMD driver's start/index/arg inputs.
// Ports:
//  iclk, irst_n               SD clock, asynchronous active-low reset
//  ostart/ocmd_index/ocmd_arg command request to the driver (index/arg held until idone)
//  iresp, idone               driver response bits [39:8] and completion pulse
//  ireq/ireq_write/iblk_addr  block command request, sampled only while oready=1
//  oready, oreq_done          idle-and-initialised flag, block command completion pulse
//  ostatus, orca              last R1 status of a block command, RCA from CMD3
//  owide_bus, ofast_clk       4-bit bus enabled, card selected (full-rate clock allowed)
//  oerror                     sticky bring-up failure
// INIT_CLKS and ACMD41_MAX must both be in 1..65535 (16-bit counters).
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter int unsigned INIT_CLKS  = 80,
  parameter int unsigned ACMD41_MAX = 1000
) (
  input  logic        iclk,
  input  logic        irst_n,
  output logic        ostart,
  output logic [5:0]  ocmd_index,
  output logic [31:0] ocmd_arg,
  input  logic [31:0] iresp,
  input  logic        idone,
  input  logic        ireq,
  input  logic        ireq_write,
  input  logic [31:0] iblk_addr,
  output logic        oready,
  output logic        oreq_done,
  output logic [31:0] ostatus,
  output logic [15:0] orca,
  output logic        owide_bus,
  output logic        ofast_clk,
  output logic        oerror
);

  localparam logic [15:0] INIT_LAST   = 16'(INIT_CLKS - 1);
  localparam logic [15:0] RETRY_LIMIT = 16'(ACMD41_MAX);

  sd_state_e   state, state_d;
  logic [15:0] wait_cnt;
  logic [15:0] retry_cnt;
  logic [15:0] retry_next;
  logic [15:0] rca;
  logic        xfer_write;
  logic [31:0] xfer_addr;

  assign orca       = rca;
  assign retry_next = retry_cnt + 16'd1;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state <= ST_PWR_WAIT;
    else         state <= state_d;
  end

  // Index/argument decode: ISSUE and WAIT of one command share the same values,
  // which keeps them stable from ostart until idone.
  always_comb begin
    ocmd_index = '0;
    ocmd_arg   = '0;
    case (state)
      ST_CMD8_ISSUE, ST_CMD8_WAIT: begin
        ocmd_index = CMD8;
        ocmd_arg   = CMD8_ARG;
      end
      ST_APP41_ISSUE, ST_APP41_WAIT, ST_APP6_ISSUE, ST_APP6_WAIT: begin
        ocmd_index = CMD55;
        ocmd_arg   = {rca, 16'h0000};
      end
      ST_ACMD41_ISSUE, ST_ACMD41_WAIT: begin
        ocmd_index = CMD41;
        ocmd_arg   = ACMD41_ARG;
      end
      ST_CMD2_ISSUE, ST_CMD2_WAIT: ocmd_index = CMD2;
      ST_CMD3_ISSUE, ST_CMD3_WAIT: ocmd_index = CMD3;
      ST_CMD7_ISSUE, ST_CMD7_WAIT: begin
        ocmd_index = CMD7;
        ocmd_arg   = {rca, 16'h0000};
      end
      ST_ACMD6_ISSUE, ST_ACMD6_WAIT: begin
        ocmd_index = ACMD6;
        ocmd_arg   = ACMD6_ARG;
      end
      ST_XFER_ISSUE, ST_XFER_WAIT: begin
        ocmd_index = xfer_write ? CMD24 : CMD17;
        ocmd_arg   = xfer_addr;
      end
      default: ;
    endcase
  end

  // Next state and control outputs
  always_comb begin
    state_d   = state;
    ostart    = 1'b0;
    oready    = 1'b0;
    oreq_done = 1'b0;
    oerror    = 1'b0;
    case (state)
      ST_PWR_WAIT:     if (wait_cnt == INIT_LAST) state_d = ST_CMD8_ISSUE;
      ST_CMD8_ISSUE:   begin ostart = 1'b1; state_d = ST_CMD8_WAIT; end
      ST_CMD8_WAIT:
        if (idone) state_d = (iresp[11:0] == CMD8_ECHO) ? ST_APP41_ISSUE : ST_ERROR;
      ST_APP41_ISSUE:  begin ostart = 1'b1; state_d = ST_APP41_WAIT; end
      ST_APP41_WAIT:   if (idone) state_d = ST_ACMD41_ISSUE;
      ST_ACMD41_ISSUE: begin ostart = 1'b1; state_d = ST_ACMD41_WAIT; end
      ST_ACMD41_WAIT:
        if (idone) begin
          if (iresp[31])                      state_d = ST_CMD2_ISSUE;
          else if (retry_next == RETRY_LIMIT) state_d = ST_ERROR;
          else                                state_d = ST_APP41_ISSUE;
        end
      ST_CMD2_ISSUE:   begin ostart = 1'b1; state_d = ST_CMD2_WAIT; end
      ST_CMD2_WAIT:    if (idone) state_d = ST_CMD3_ISSUE;
      ST_CMD3_ISSUE:   begin ostart = 1'b1; state_d = ST_CMD3_WAIT; end
      ST_CMD3_WAIT:    if (idone) state_d = ST_CMD7_ISSUE;
      ST_CMD7_ISSUE:   begin ostart = 1'b1; state_d = ST_CMD7_WAIT; end
      ST_CMD7_WAIT:    if (idone) state_d = ST_APP6_ISSUE;
      ST_APP6_ISSUE:   begin ostart = 1'b1; state_d = ST_APP6_WAIT; end
      ST_APP6_WAIT:    if (idone) state_d = ST_ACMD6_ISSUE;
      ST_ACMD6_ISSUE:  begin ostart = 1'b1; state_d = ST_ACMD6_WAIT; end
      ST_ACMD6_WAIT:   if (idone) state_d = ST_READY;
      ST_READY: begin
        oready = 1'b1;
        if (ireq) state_d = ST_XFER_ISSUE;
      end
      ST_XFER_ISSUE:   begin ostart = 1'b1; state_d = ST_XFER_WAIT; end
      ST_XFER_WAIT:
        if (idone) begin
          oreq_done = 1'b1;
          state_d   = ST_READY;
        end
      ST_ERROR:        oerror = 1'b1;
      default:         state_d = ST_PWR_WAIT;
    endcase
  end

  // Counters and captured card data
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      wait_cnt   <= '0;
      retry_cnt  <= '0;
      rca        <= '0;
      xfer_write <= 1'b0;
      xfer_addr  <= '0;
      ostatus    <= '0;
      owide_bus  <= 1'b0;
      ofast_clk  <= 1'b0;
    end else begin
      if (state == ST_PWR_WAIT) wait_cnt <= wait_cnt + 16'd1;
      if (state == ST_ACMD41_WAIT && idone && !iresp[31]) retry_cnt <= retry_next;
      if (state == ST_CMD3_WAIT && idone) rca <= iresp[31:16];
      if (state == ST_CMD7_WAIT && idone) ofast_clk <= 1'b1;
      if (state == ST_ACMD6_WAIT && idone) owide_bus <= 1'b1;
      if (state == ST_READY && ireq) begin
        xfer_write <= ireq_write;
        xfer_addr  <= iblk_addr;
      end
      if (state == ST_XFER_WAIT && idone) ostatus <= iresp;
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Testbench for sd_cmd_sequencer: a behavioural card answers every command after a
// random latency; the expected command stream is planned from the bring-up rules and
// pushed into a queue, and a monitor pops and compares on every ostart / oreq_done.
module tb_sd_cmd_sequencer;

  localparam int unsigned INIT_CLKS  = 80;
  localparam int unsigned ACMD41_MAX = 5;

  logic        iclk = 1'b0;
  logic        irst_n = 1'b1;
  logic        ostart;
  logic [5:0]  ocmd_index;
  logic [31:0] ocmd_arg;
  logic [31:0] iresp;
  logic        idone;
  logic        ireq = 1'b0;
  logic        ireq_write = 1'b0;
  logic [31:0] iblk_addr = '0;
  logic        oready, oreq_done, owide_bus, ofast_clk, oerror;
  logic [31:0] ostatus;
  logic [15:0] orca;

  always #5 iclk = ~iclk;

  sd_cmd_sequencer #(.INIT_CLKS(INIT_CLKS), .ACMD41_MAX(ACMD41_MAX)) dut (
    .iclk(iclk), .irst_n(irst_n), .ostart(ostart), .ocmd_index(ocmd_index),
    .ocmd_arg(ocmd_arg), .iresp(iresp), .idone(idone), .ireq(ireq),
    .ireq_write(ireq_write), .iblk_addr(iblk_addr), .oready(oready),
    .oreq_done(oreq_done), .ostatus(ostatus), .orca(orca), .owide_bus(owide_bus),
    .ofast_clk(ofast_clk), .oerror(oerror)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  function void check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  function void unexpected(string name, logic [63:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h, required nothing", name, act);
  endfunction

  // Scoreboard queues
  logic [37:0] exp_cmd_q[$];   // {index, arg}
  logic [31:0] status_q[$];    // R1 status the card returned for block commands

  // Card model configuration
  bit          cfg_cmd8_ok;
  int unsigned busy_left;
  logic [15:0] cfg_rca;
  bit          spurious_en;

  function logic [31:0] card_answer(logic [5:0] idx);
    logic [31:0] r;
    case (idx)
      6'd8:  r = cfg_cmd8_ok ? 32'h0000_01AA : 32'h0000_01A5;
      6'd41: begin
        if (busy_left > 0) begin
          busy_left--;
          r = 32'h00FF_8000;
        end else begin
          r = 32'hC0FF_8000;
        end
      end
      6'd3:  r = {cfg_rca, 16'h0500};
      6'd17, 6'd24: begin
        r = $urandom;
        status_q.push_back(r);
      end
      default: r = $urandom;
    endcase
    return r;
  endfunction

  // Card: answer each ostart after 1..5 cycles; optionally inject idone while idle
  bit          pending = 1'b0;
  bit          real_done = 1'b0;
  int unsigned lat;
  logic [31:0] resp;
  initial begin
    idone = 1'b0;
    iresp = '0;
    forever begin
      @(posedge iclk);
      #1;
      idone     = 1'b0;
      real_done = 1'b0;
      if (!irst_n) begin
        pending = 1'b0;
      end else if (pending) begin
        if (lat == 0) begin
          idone     = 1'b1;
          real_done = 1'b1;
          iresp     = resp;
          pending   = 1'b0;
        end else begin
          lat--;
        end
      end else if (ostart) begin
        pending = 1'b1;
        lat     = $urandom_range(0, 4);
        resp    = card_answer(ocmd_index);
      end else if (spurious_en && $urandom_range(0, 7) == 0) begin
        idone = 1'b1;
        iresp = $urandom;
      end
    end
  end

  int unsigned cyc;
  always @(posedge iclk or negedge irst_n) begin
    if (!irst_n) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Monitor
  bit          seen_first;
  int unsigned first_cyc;
  int unsigned done_cnt;
  logic [37:0] cur_cmd = '0;
  bit          chk_status_pend = 1'b0;
  logic [31:0] chk_status_exp;
  always @(negedge iclk) begin
    if (!irst_n) begin
      chk_status_pend = 1'b0;
    end else begin
      if (chk_status_pend) begin
        check("ostatus", 64'(ostatus), 64'(chk_status_exp));
        check("oready_after_done", 64'(oready), 64'd1);
        chk_status_pend = 1'b0;
      end
      if (ostart) begin
        if (!seen_first) begin
          seen_first = 1'b1;
          first_cyc  = cyc;
        end
        if (exp_cmd_q.size() == 0) begin
          unexpected("unexpected_ostart", 64'({ocmd_index, ocmd_arg}));
        end else begin
          cur_cmd = exp_cmd_q.pop_front();
          check("cmd", 64'({ocmd_index, ocmd_arg}), 64'(cur_cmd));
          if (cur_cmd[37:32] == 6'd7) check("fast_before_cmd7", 64'(ofast_clk), 64'd0);
          if (cur_cmd[37:32] == 6'd6) begin
            check("fast_before_acmd6", 64'(ofast_clk), 64'd1);
            check("wide_before_acmd6", 64'(owide_bus), 64'd0);
          end
        end
      end
      if (real_done) check("cmd_hold", 64'({ocmd_index, ocmd_arg}), 64'(cur_cmd));
      if (oreq_done) begin
        done_cnt++;
        check("oready_at_done", 64'(oready), 64'd0);
        check("done_with_idone", 64'(real_done), 64'd1);
        if (status_q.size() == 0) begin
          unexpected("unexpected_req_done", 64'(ostatus));
        end else begin
          chk_status_exp  = status_q.pop_front();
          chk_status_pend = 1'b1;
        end
      end
    end
  end

  // Reference plan of the bring-up command stream
  task automatic plan_init(bit cmd8_ok, int unsigned nfail, logic [15:0] rca);
    exp_cmd_q.push_back({6'd8, 32'h0000_01AA});
    if (!cmd8_ok) return;
    for (int unsigned p = 0; p < ACMD41_MAX; p++) begin
      exp_cmd_q.push_back({6'd55, 32'h0});
      exp_cmd_q.push_back({6'd41, 32'h40FF_8000});
      if (p == nfail) break;
    end
    if (nfail >= ACMD41_MAX) return;
    exp_cmd_q.push_back({6'd2, 32'h0});
    exp_cmd_q.push_back({6'd3, 32'h0});
    exp_cmd_q.push_back({6'd7, rca, 16'h0});
    exp_cmd_q.push_back({6'd55, rca, 16'h0});
    exp_cmd_q.push_back({6'd6, 32'h2});
  endtask

  task automatic start_run(bit cmd8_ok, int unsigned nfail, logic [15:0] rca, bit spur);
    irst_n = 1'b0;
    ireq   = 1'b0;
    #1;
    check("rst_ctrl", 64'({ostart, oready, oreq_done, owide_bus, ofast_clk, oerror}), 64'd0);
    check("rst_cmd", 64'({ocmd_index, ocmd_arg}), 64'd0);
    check("rst_data", 64'({ostatus, orca}), 64'd0);
    repeat (2) @(posedge iclk);
    exp_cmd_q.delete();
    status_q.delete();
    cfg_cmd8_ok = cmd8_ok;
    busy_left   = nfail;
    cfg_rca     = rca;
    spurious_en = spur;
    seen_first  = 1'b0;
    done_cnt    = 0;
    plan_init(cmd8_ok, nfail, rca);
    @(negedge iclk);
    irst_n = 1'b1;
  endtask

  task automatic wait_settle(bit want_ready, int unsigned budget, bit noise);
    bit ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(posedge iclk);
      #2;
      if (want_ready ? oready : oerror) begin
        ok = 1'b1;
        break;
      end
      ireq       = noise ? 1'($urandom) : 1'b0;
      ireq_write = 1'($urandom);
      iblk_addr  = $urandom;
    end
    ireq = 1'b0;
    check(want_ready ? "settle_ready" : "settle_error", 64'(ok), 64'd1);
  endtask

  task automatic do_xfer(bit wr, logic [31:0] addr, bit poke);
    bit ok = 1'b0;
    check("ready_before_req", 64'(oready), 64'd1);
    ireq       = 1'b1;
    ireq_write = wr;
    iblk_addr  = addr;
    exp_cmd_q.push_back({wr ? 6'd24 : 6'd17, addr});
    @(posedge iclk);
    #2;
    check("req_to_ostart", 64'(ostart), 64'd1);
    check("oready_in_xfer", 64'(oready), 64'd0);
    ireq_write = ~wr;
    iblk_addr  = ~addr;
    ireq       = poke;
    for (int unsigned i = 0; i < 40; i++) begin
      @(posedge iclk);
      #2;
      if (oready) begin
        ok = 1'b1;
        break;
      end
      ireq = poke;
    end
    ireq = 1'b0;
    check("xfer_settle", 64'(ok), 64'd1);
  endtask

  initial begin
    logic [15:0] rca;
    bit          saw_ready;
    #3;

    // Ideal card, ireq noise during init, spurious idone while idle
    rca = 16'($urandom);
    start_run(1'b1, 0, rca, 1'b1);
    wait_settle(1'b1, 400, 1'b1);
    check("first_ostart_cycle", 64'(first_cyc), 64'(INIT_CLKS));
    check("init_flags", 64'({owide_bus, ofast_clk, oerror}), 64'b110);
    check("orca", 64'(orca), 64'(rca));
    check("init_cmds_left", 64'(exp_cmd_q.size()), 64'd0);
    for (int unsigned i = 0; i < 6; i++)
      do_xfer(1'($urandom), $urandom, 1'(i % 2));
    repeat (30) @(posedge iclk);
    #2;
    check("xfer_count", 64'(done_cnt), 64'd6);
    check("ready_idle", 64'(oready), 64'd1);
    check("xfer_cmds_left", 64'(exp_cmd_q.size() + status_q.size()), 64'd0);

    // Bad CMD8 echo: terminal error
    start_run(1'b0, 0, 16'h0, 1'b1);
    wait_settle(1'b0, 300, 1'b1);
    saw_ready = 1'b0;
    for (int unsigned i = 0; i < 100; i++) begin
      @(posedge iclk);
      #2;
      if (oready) saw_ready = 1'b1;
      ireq = 1'($urandom);
    end
    ireq = 1'b0;
    check("cmd8_err_oerror", 64'(oerror), 64'd1);
    check("cmd8_err_ready", 64'(saw_ready), 64'd0);
    check("cmd8_err_cmds_left", 64'(exp_cmd_q.size()), 64'd0);

    // Three busy ACMD41 answers, then ready
    rca = 16'($urandom);
    start_run(1'b1, 3, rca, 1'b0);
    wait_settle(1'b1, 600, 1'b0);
    check("busy3_cmds_left", 64'(exp_cmd_q.size()), 64'd0);
    check("busy3_wide", 64'(owide_bus), 64'd1);

    // Card never leaves busy: give up after ACMD41_MAX pairs
    start_run(1'b1, 1000, 16'h1111, 1'b0);
    wait_settle(1'b0, 800, 1'b0);
    repeat (50) @(posedge iclk);
    #2;
    check("busy_max_cmds_left", 64'(exp_cmd_q.size()), 64'd0);
    check("busy_max_flags", 64'({oerror, oready, ofast_clk, owide_bus}), 64'b1000);

    // Fixed RCA, one transfer, then reset in the middle of a second one
    start_run(1'b1, 0, 16'hB368, 1'b0);
    wait_settle(1'b1, 400, 1'b0);
    check("rca_b368", 64'(orca), 64'hB368);
    check("fast_after_cmd7", 64'(ofast_clk), 64'd1);
    do_xfer(1'b1, 32'h0000_1234, 1'b1);
    check("xfer_count_b368", 64'(done_cnt), 64'd1);
    ireq       = 1'b1;
    ireq_write = 1'b0;
    iblk_addr  = 32'h0000_5678;
    exp_cmd_q.push_back({6'd17, 32'h0000_5678});
    @(posedge iclk);
    #2;
    ireq = 1'b0;
    @(posedge iclk);
    #2;
    start_run(1'b1, 0, 16'h0042, 1'b0);
    wait_settle(1'b1, 400, 1'b0);
    check("restart_first_ostart", 64'(first_cyc), 64'(INIT_CLKS));
    check("restart_orca", 64'(orca), 64'h0042);
    check("restart_no_done", 64'(done_cnt), 64'd0);
    do_xfer(1'b0, 32'hDEAD_BEEF, 1'b0);
    repeat (3) @(posedge iclk);
    check("restart_xfer_count", 64'(done_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
